// File: rtl/traffic_ctrl_np_if.sv
// Shared definitions and the signal bundle of the N-phase traffic-light controller.
//
// traffic_ctrl_np_pkg
//   color_e : lamp code driven per phase (RED, GREEN, YELLOW, FLASH).
//   state_e : controller state, exported for observation.
//
// traffic_ctrl_np_if #(NUM_PHASES)
//   sensor_i   : vehicle present, one bit per phase, bit 0 = main road.
//   lights_o   : lamp code per phase, phase i at bits [2i+1:2i].
//   phase_id_o : phase currently owning green, yellow or clearance.
//   preempt_i  : emergency preemption request (only with TRAFFIC_PREEMPT_EN).
//   modport slave  : controller side.
//   modport master : sensor / supervisor side.
//
// There is no valid/ready handshake on this bundle. Every signal is a level,
// sampled by the controller on each rising clock edge; outputs are registered
// and change only on prescaler ticks.
//
// Optional feature macro: TRAFFIC_PREEMPT_EN adds preempt_i.

package traffic_ctrl_np_pkg;
    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        FLASH  = 2'd3
    } color_e;

    typedef enum logic [2:0] {
        ST_FLASH   = 3'd0,
        ST_STARTUP = 3'd1,
        ST_GREEN   = 3'd2,
        ST_YELLOW  = 3'd3,
        ST_ALL_RED = 3'd4
    } state_e;
endpackage

interface traffic_ctrl_np_if #(
    parameter int NUM_PHASES = 3
) ();
    logic [NUM_PHASES-1:0]         sensor_i;
    logic [2*NUM_PHASES-1:0]       lights_o;
    logic [$clog2(NUM_PHASES)-1:0] phase_id_o;
`ifdef TRAFFIC_PREEMPT_EN
    logic                          preempt_i;

    modport slave  (input sensor_i, preempt_i, output lights_o, phase_id_o);
    modport master (output sensor_i, preempt_i, input lights_o, phase_id_o);
`else
    modport slave  (input sensor_i, output lights_o, phase_id_o);
    modport master (output sensor_i, input lights_o, phase_id_o);
`endif
endinterface

// File: rtl/traffic_ctrl_np.sv
// N-phase traffic-light controller.
//
// Phase 0 is the main road and rests in green. Side phases 1..NUM_PHASES-1
// are served on latched sensor demand in round-robin order, each followed by
// a return to main. All durations are in ticks produced by a prescaler.
//
// Ports
//   clk_i   : system clock.
//   rst_ni  : asynchronous active-low reset (all lamps FLASH while low).
//   bus     : traffic_ctrl_np_if.slave (sensor_i, lights_o, phase_id_o,
//             and preempt_i when TRAFFIC_PREEMPT_EN is defined).
//   state_o : current controller state, for observation.
//
// Optional feature macro: TRAFFIC_PREEMPT_EN (emergency preemption to main).

module traffic_ctrl_np
    import traffic_ctrl_np_pkg::*;
#(
    parameter int NUM_PHASES   = 3,
    parameter int TICK_DIV     = 1,
    parameter int MAIN_GREEN_T = 45,
    parameter int SIDE_GREEN_T = 15,
    parameter int YELLOW_T     = 5,
    parameter int ALL_RED_T    = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    traffic_ctrl_np_if.slave bus,
    output state_e           state_o
);
    localparam int PIW   = $clog2(NUM_PHASES);
    localparam int LW    = 2 * NUM_PHASES;
    localparam int MAX_A = (MAIN_GREEN_T > SIDE_GREEN_T) ? MAIN_GREEN_T : SIDE_GREEN_T;
    localparam int MAX_B = (YELLOW_T > ALL_RED_T) ? YELLOW_T : ALL_RED_T;
    localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(MAX_T) + 1;
    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] CNT_LAST  = PW'(TICK_DIV - 1);
    // A state ends on the tick where the timer has already counted DUR-1 ticks.
    localparam logic [TW-1:0] MAIN_LAST = TW'(MAIN_GREEN_T - 1);
    localparam logic [TW-1:0] SIDE_LAST = TW'(SIDE_GREEN_T - 1);
    localparam logic [TW-1:0] YEL_LAST  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'(ALL_RED_T - 1);

    logic [PW-1:0]         cnt_q, cnt_d;
    state_e                state_q, state_d;
    logic [PIW-1:0]        phase_q, phase_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [PIW-1:0]        rr_q, rr_d;
    logic [NUM_PHASES-1:0] latch_q, latch_d;
    logic [LW-1:0]         lights_q, lights_d;

    logic                  tick;
    logic                  preempt;
    logic                  go_green;
    logic                  found;
    logic [PIW-1:0]        found_idx;
    logic [PIW:0]          sum;
    logic [NUM_PHASES-1:0] clr;

`ifdef TRAFFIC_PREEMPT_EN
    assign preempt = bus.preempt_i;
`else
    assign preempt = 1'b0;
`endif

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    function automatic logic [LW-1:0] lamps(input state_e st, input logic [PIW-1:0] ph);
        logic [LW-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (st == ST_FLASH)                          v[2*i +: 2] = FLASH;
            else if (st == ST_GREEN  && ph == PIW'(i))   v[2*i +: 2] = GREEN;
            else if (st == ST_YELLOW && ph == PIW'(i))   v[2*i +: 2] = YELLOW;
            else                                         v[2*i +: 2] = RED;
        end
        return v;
    endfunction

    // First latched side phase at or above the pointer, wrapping within 1..N-1.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        sum       = '0;
        for (int k = 0; k < NUM_PHASES - 1; k++) begin
            sum = {1'b0, rr_q} + (PIW+1)'(k);
            if (sum >= (PIW+1)'(NUM_PHASES)) sum = sum - (PIW+1)'(NUM_PHASES - 1);
            if (!found && latch_q[sum[PIW-1:0]]) begin
                found     = 1'b1;
                found_idx = sum[PIW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        timer_d  = timer_q;
        rr_d     = rr_q;
        go_green = 1'b0;
        if (tick) begin
            if (timer_q != '1) timer_d = timer_q + 1'b1;
            case (state_q)
                ST_FLASH: begin
                    state_d = ST_STARTUP;
                    phase_d = '0;
                    timer_d = '0;
                end
                ST_STARTUP: begin
                    if (timer_q >= AR_LAST) begin
                        state_d  = ST_GREEN;
                        phase_d  = '0;
                        timer_d  = '0;
                        go_green = 1'b1;
                    end
                end
                ST_GREEN: begin
                    if (phase_q == '0) begin
                        // Main has no upper limit; it yields only to latched demand.
                        if (!preempt && timer_q >= MAIN_LAST && |latch_q) begin
                            state_d = ST_YELLOW;
                            timer_d = '0;
                        end
                    end else if (preempt || timer_q >= SIDE_LAST) begin
                        state_d = ST_YELLOW;
                        timer_d = '0;
                    end
                end
                ST_YELLOW: begin
                    if (timer_q >= YEL_LAST) begin
                        state_d = ST_ALL_RED;
                        timer_d = '0;
                    end
                end
                ST_ALL_RED: begin
                    if (timer_q >= AR_LAST) begin
                        state_d  = ST_GREEN;
                        timer_d  = '0;
                        go_green = 1'b1;
                        phase_d  = '0;
                        if (phase_q == '0 && found) begin
                            phase_d = found_idx;
                            rr_d    = (found_idx == PIW'(NUM_PHASES - 1)) ? PIW'(1)
                                                                          : found_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_FLASH;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Set wins over clear, so a sensor still high at green entry re-requests.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            clr[i] = go_green && (phase_d == PIW'(i));
        end
        latch_d    = (latch_q & ~clr) | bus.sensor_i;
        latch_d[0] = 1'b0;
        lights_d   = lamps(state_d, phase_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            state_q  <= ST_FLASH;
            phase_q  <= '0;
            timer_q  <= '0;
            rr_q     <= PIW'(1);
            latch_q  <= '0;
            lights_q <= {NUM_PHASES{FLASH}};
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            rr_q     <= rr_d;
            latch_q  <= latch_d;
            lights_q <= lights_d;
        end
    end

    assign bus.lights_o   = lights_q;
    assign bus.phase_id_o = phase_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_traffic_ctrl_np.sv
// Bench for traffic_ctrl_np: dut_a runs with TICK_DIV=1, dut_b with TICK_DIV=4.
// Expected {phase_id, lights} per clock are pushed as segments and popped one
// per falling edge.
module tb_traffic_ctrl_np;
    import traffic_ctrl_np_pkg::*;

    localparam int N = 3;
    localparam int W = 8;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic   rst_n;
    logic   rst_b_n;
    state_e state_a;
    state_e state_b;

    traffic_ctrl_np_if #(.NUM_PHASES(N)) bus_a ();
    traffic_ctrl_np_if #(.NUM_PHASES(N)) bus_b ();

    traffic_ctrl_np #(.NUM_PHASES(N), .TICK_DIV(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_a), .state_o(state_a)
    );
    traffic_ctrl_np #(.NUM_PHASES(N), .TICK_DIV(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_b_n), .bus(bus_b), .state_o(state_b)
    );

    // scoreboard
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ph < 0: every phase shows col; otherwise phase ph shows col, rest RED.
    function automatic logic [5:0] mk(input int ph, input logic [1:0] col);
        logic [5:0] v;
        for (int i = 0; i < N; i++) v[2*i +: 2] = (ph < 0 || i == ph) ? col : 2'(RED);
        return v;
    endfunction

    task automatic push_seg(input int owner, input int ph, input logic [1:0] col, input int n);
        logic [1:0] o;
        o = owner[1:0];
        repeat (n) exp_q.push_back({o, mk(ph, col)});
    endtask

    task automatic drain(input string tag, input bit sel);
        logic [W-1:0] e;
        logic [W-1:0] obs;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            obs = sel ? {bus_b.phase_id_o, bus_b.lights_o} : {bus_a.phase_id_o, bus_a.lights_o};
            check(tag, obs, e);
        end
    endtask

    // Asynchronous reset of dut_a from mid-cycle; released on a falling edge.
    task automatic reset_a(input string tag, input logic [2:0] sens);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_async"}, {bus_a.phase_id_o, bus_a.lights_o}, {2'd0, mk(-1, FLASH)});
        check({tag, "_state"}, {5'd0, state_a}, {5'd0, ST_FLASH});
        repeat (3) begin
            @(negedge clk);
            check({tag, "_hold"}, {bus_a.phase_id_o, bus_a.lights_o}, {2'd0, mk(-1, FLASH)});
        end
        bus_a.sensor_i = sens;
        rst_n = 1'b1;
    endtask

    // driver / directed sequence
    initial begin
        rst_n = 1'b0;
        rst_b_n = 1'b0;
        bus_a.sensor_i = '0;
        bus_b.sensor_i = '0;
`ifdef TRAFFIC_PREEMPT_EN
        bus_a.preempt_i = 1'b0;
        bus_b.preempt_i = 1'b0;
`endif
        // reset held for 4 clocks
        repeat (4) begin
            @(negedge clk);
            check("reset_a", {bus_a.phase_id_o, bus_a.lights_o}, {2'd0, mk(-1, FLASH)});
            check("reset_b", {bus_b.phase_id_o, bus_b.lights_o}, {2'd0, mk(-1, FLASH)});
        end

        // all sensors present: full round-robin cycle
        bus_a.sensor_i = 3'b111;
        rst_n = 1'b1;
        push_seg(0, -1, RED, 1);
        push_seg(0, 0, GREEN, 45);
        push_seg(0, 0, YELLOW, 5);
        push_seg(0, -1, RED, 1);
        push_seg(1, 1, GREEN, 15);
        push_seg(1, 1, YELLOW, 5);
        push_seg(1, -1, RED, 1);
        push_seg(0, 0, GREEN, 45);
        push_seg(0, 0, YELLOW, 5);
        push_seg(0, -1, RED, 1);
        push_seg(2, 2, GREEN, 15);
        push_seg(2, 2, YELLOW, 2);
        drain("rr_cycle", 1'b0);

        // reset in the middle of side yellow, then main-only traffic
        reset_a("rst_mid_yellow", 3'b001);
        push_seg(0, -1, RED, 1);
        push_seg(0, 0, GREEN, 200);
        drain("main_rest", 1'b0);

        // one-clock pulse on sensor 2 at main green tick 10
        reset_a("rst_pulse", 3'b000);
        push_seg(0, -1, RED, 1);
        push_seg(0, 0, GREEN, 10);
        drain("pulse_pre", 1'b0);
        bus_a.sensor_i = 3'b100;
        push_seg(0, 0, GREEN, 1);
        drain("pulse_edge", 1'b0);
        bus_a.sensor_i = 3'b000;
        push_seg(0, 0, GREEN, 34);
        push_seg(0, 0, YELLOW, 5);
        push_seg(0, -1, RED, 1);
        push_seg(2, 2, GREEN, 15);
        push_seg(2, 2, YELLOW, 5);
        push_seg(2, -1, RED, 1);
        push_seg(0, 0, GREEN, 60);
        drain("pulse_serve", 1'b0);

`ifdef TRAFFIC_PREEMPT_EN
        // preemption cuts side green, holds main, then normal rules resume
        reset_a("rst_preempt", 3'b010);
        push_seg(0, -1, RED, 1);
        push_seg(0, 0, GREEN, 45);
        push_seg(0, 0, YELLOW, 5);
        push_seg(0, -1, RED, 1);
        push_seg(1, 1, GREEN, 3);
        drain("pre_side", 1'b0);
        bus_a.preempt_i = 1'b1;
        bus_a.sensor_i = 3'b110;
        push_seg(1, 1, YELLOW, 5);
        push_seg(1, -1, RED, 1);
        push_seg(0, 0, GREEN, 60);
        drain("pre_hold", 1'b0);
        bus_a.preempt_i = 1'b0;
        push_seg(0, 0, YELLOW, 5);
        push_seg(0, -1, RED, 1);
        push_seg(2, 2, GREEN, 15);
        push_seg(2, 2, YELLOW, 5);
        push_seg(2, -1, RED, 1);
        push_seg(0, 0, GREEN, 45);
        push_seg(0, 0, YELLOW, 5);
        push_seg(0, -1, RED, 1);
        push_seg(1, 1, GREEN, 3);
        drain("pre_resume", 1'b0);
`endif

        // prescaled timing on dut_b: every duration times 4 clocks
        @(negedge clk);
        bus_b.sensor_i = 3'b010;
        rst_b_n = 1'b1;
        push_seg(0, -1, FLASH, 3);
        push_seg(0, -1, RED, 4);
        push_seg(0, 0, GREEN, 180);
        push_seg(0, 0, YELLOW, 20);
        push_seg(0, -1, RED, 4);
        push_seg(1, 1, GREEN, 60);
        push_seg(1, 1, YELLOW, 20);
        push_seg(1, -1, RED, 4);
        push_seg(0, 0, GREEN, 8);
        drain("tick_div4", 1'b1);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_ctrl_np.md
Name: traffic_ctrl_np

Overview:
- Parametrised N-phase traffic-light controller; successor to the fixed two-road controller.
- Phase 0 is the main road and the default rest phase. Phases 1..NUM_PHASES-1 are side roads, served on latched sensor demand in round-robin order.
- All durations are parameters counted in ticks; a tick prescaler decouples timing from the clock rate.
- Sits between the per-approach sensor inputs and the lamp drivers; lamp codes use the shared color type from defs.sv (RED, GREEN, YELLOW, FLASH).

Parameters:
- NUM_PHASES, 3, number of phases incl. main; legal 2..8.
- TICK_DIV, 1, clocks per tick; 1 means every clock is a tick.
- MAIN_GREEN_T, 45, minimum main green in ticks.
- SIDE_GREEN_T, 15, fixed side-phase green in ticks.
- YELLOW_T, 5, yellow duration in ticks.
- ALL_RED_T, 1, all-red clearance in ticks; also the start-up red duration.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Sensor  in  NUM_PHASES  vehicle present, one bit per phase; bit 0 = main.
- Lights  out  2*NUM_PHASES  lamp code per phase; phase i at bits [2i+1:2i].
- PhaseId  out  $clog2(NUM_PHASES)  phase currently owning green, yellow or clearance.
- Preempt  in  1  emergency preemption request; present only with TRAFFIC_PREEMPT_EN.

Behaviour:
- Reset low (asynchronous): all Lights = FLASH, PhaseId = 0, demand latches cleared, timers and prescaler cleared, round-robin pointer = 1, state = FLASH.
- Reset release: STARTUP (all RED) for ALL_RED_T ticks, then main GREEN.
- Prescaler: counts 0..TICK_DIV-1. The tick pulse fires when the count wraps. All timers and state changes act only on ticks. Lights are registered and change on the tick edge.
- Demand: side latch i sets on any clock where Sensor[i] is high. It clears when phase i enters GREEN. Sensor[0] does not affect sequencing.
- States: FLASH, STARTUP, GREEN, YELLOW, ALL_RED. The phase timer resets on every state entry.
- Main GREEN: hold while no side demand is latched, with no upper limit. Go to YELLOW on the first tick where elapsed >= MAIN_GREEN_T and any side latch is set. Demand arriving before the minimum is honoured at the minimum.
- Side GREEN: exactly SIDE_GREEN_T ticks, regardless of that phase's sensor, then YELLOW.
- YELLOW: exactly YELLOW_T ticks, then ALL_RED. Only the owning phase shows YELLOW; all others show RED.
- ALL_RED: exactly ALL_RED_T ticks with all phases RED, then the next phase goes GREEN.
  - After a side phase: next is always phase 0.
  - After main: next is the first phase with a set latch, searching upward from the pointer and wrapping 1..NUM_PHASES-1. The pointer then becomes served phase+1, wrapping to 1.
- Simultaneous events: a sensor rising on the same clock its latch clears leaves the latch set, because set wins. The served phase is therefore re-requested.
- Exactly one phase may be non-RED at any time; the FLASH state is the only exception.
- Reset mid-phase: immediate FLASH; there is no yellow run-out.
- Timer width: $clog2 of the largest duration + 1. Saturating, no wrap.

Optional Feature:
- Macro TRAFFIC_PREEMPT_EN.
- Defined: Preempt port exists.
  - Preempt high during side GREEN: go to YELLOW on the next tick, cutting green short, then ALL_RED, then main GREEN.
  - Main GREEN is held unconditionally while Preempt is high; side demand stays latched.
  - Preempt high during YELLOW or ALL_RED of a side phase: sequence completes normally into main GREEN.
  - On Preempt low, normal rules resume, and the main minimum counts from main GREEN entry.
- Undefined: no Preempt port; behaviour as above with no preemption.

Test Plan:
1. Reset low 4 clocks, then high with Sensor=3'b111, TICK_DIV=1:
   - FLASH on all phases while low.
   - RED,RED,RED for 1 tick after release.
   - Main GREEN for 45 ticks, YELLOW for 5, all RED for 1.
   - Phase 1 GREEN for 15, YELLOW for 5, all RED for 1.
   - Main GREEN, then phase 2 GREEN (round-robin).
2. Sensor=3'b001 for 200 ticks -> main stays GREEN throughout; PhaseId=0.
3. Sensor[2] pulsed high for 1 clock at main-green tick 10, then held low -> at tick 45 main YELLOW; phase 2 GREEN 15 ticks, latch cleared; then main GREEN held.
4. Reset low mid side-YELLOW -> all FLASH the same cycle with no clock needed; release yields STARTUP red and main GREEN.
5. TICK_DIV=4, Sensor=3'b010 -> every duration scales by 4 clocks; main green lasts 180 clocks.
6. TRAFFIC_PREEMPT_EN defined, Preempt raised at phase 1 green tick 3:
   - YELLOW for 5, all RED for 1, then main GREEN held while Preempt is high even with Sensor=3'b110.
   - After Preempt drops, phase 1 is served no earlier than 45 ticks after main GREEN entry.
